// File: rtl/alu.sv
// Registered 32-bit EX-stage ALU: result, zero and signed-overflow flags captured when en is high.
// Latency 1 cycle, no input-to-output combinational path; no backpressure, en=0 simply holds the outputs.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUop,
    output logic [WIDTH-1:0] C,
    output logic             zero,
    output logic             overflow
);

    localparam logic [3:0] OP_ADDU  = 4'b0000;
    localparam logic [3:0] OP_SUBU  = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NOR   = 4'b0101;
    localparam logic [3:0] OP_SLTU  = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;
    localparam logic [3:0] OP_LUI   = 4'b1011;
    localparam logic [3:0] OP_ADD   = 4'b1100;
    localparam logic [3:0] OP_SUB   = 4'b1101;
    localparam logic [3:0] OP_PASSA = 4'b1110;
    localparam logic [3:0] OP_PASSB = 4'b1111;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [4:0]       shamt;
    logic             lt_u;
    logic             lt_s;
    logic [WIDTH-1:0] res;
    logic             ovf;

    assign sum   = A + B;
    assign diff  = A - B;
    assign shamt = A[4:0];
    assign lt_u  = A < B;
    assign lt_s  = $signed(A) < $signed(B);

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (ALUop)
            OP_ADDU:  res = sum;
            OP_SUBU:  res = diff;
            OP_AND:   res = A & B;
            OP_OR:    res = A | B;
            OP_XOR:   res = A ^ B;
            OP_NOR:   res = ~(A | B);
            OP_SLTU:  res = {{(WIDTH-1){1'b0}}, lt_u};
            OP_SLT:   res = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLL:   res = B << shamt;
            OP_SRL:   res = B >> shamt;
            OP_SRA:   res = $signed(B) >>> shamt;
            OP_LUI:   res = {B[15:0], {(WIDTH-16){1'b0}}};
            // Trapping variants still return the wrapped value; the pipeline decides what to do.
            OP_ADD: begin
                res = sum;
                ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff;
                ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_PASSA: res = A;
            OP_PASSB: res = B;
            default:  res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            C        <= '0;
            zero     <= 1'b1;
            overflow <= 1'b0;
        end else if (en) begin
            C        <= res;
            zero     <= (res == '0);
            overflow <= ovf;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: arithmetic reference model checked every cycle, plus directed literal expectations.
module tb_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUop;
    logic [31:0] C;
    logic        zero;
    logic        overflow;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] exp_c = '0;
    logic        exp_z = 1'b1;
    logic        exp_o = 1'b0;
    bit          armed = 1'b0;

    always #5 clk = ~clk;

    alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .en(en), .A(A), .B(B), .ALUop(ALUop),
        .C(C), .zero(zero), .overflow(overflow)
    );

    // Reference: shifts as multiply/divide by powers of two, overflow from 64-bit range.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] op,
                                  output logic [31:0] c, output logic o);
        logic [31:0] pw;
        longint      s;
        longint      lim;
        pw  = 32'd1 << {27'd0, a[4:0]};
        lim = 64'sd2147483647;
        o   = 1'b0;
        c   = '0;
        case (op)
            4'd0:  c = a + b;
            4'd1:  c = a - b;
            4'd2:  c = a & b;
            4'd3:  c = a | b;
            4'd4:  c = a ^ b;
            4'd5:  c = ~(a | b);
            4'd6:  c = (a < b) ? 32'd1 : 32'd0;
            4'd7:  c = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  c = b * pw;
            4'd9:  c = b / pw;
            4'd10: c = b[31] ? ~((~b) / pw) : (b / pw);
            4'd11: c = b * 32'd65536;
            4'd12: begin
                s = longint'($signed(a)) + longint'($signed(b));
                c = s[31:0];
                o = (s > lim) || (s < -lim - 1);
            end
            4'd13: begin
                s = longint'($signed(a)) - longint'($signed(b));
                c = s[31:0];
                o = (s > lim) || (s < -lim - 1);
            end
            4'd14: c = a;
            default: c = b;
        endcase
    endfunction

    always @(posedge clk) begin : mdl
        logic [31:0] mc;
        logic        mo;
        if (!reset) begin
            exp_c <= '0;
            exp_z <= 1'b1;
            exp_o <= 1'b0;
            armed <= 1'b1;
        end else if (en) begin
            model(A, B, ALUop, mc, mo);
            exp_c <= mc;
            exp_z <= (mc == 32'd0);
            exp_o <= mo;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            n_chk++;
            if (C !== exp_c || zero !== exp_z || overflow !== exp_o) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: got C=%h zero=%b ovf=%b, required C=%h zero=%b ovf=%b",
                         $time, C, zero, overflow, exp_c, exp_z, exp_o);
            end
        end
    end

    task automatic cyc(input logic r, input logic e, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] op);
        reset = r;
        en    = e;
        A     = a;
        B     = b;
        ALUop = op;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] ec, input logic ez, input logic eo);
        n_chk++;
        if (C !== ec || zero !== ez || overflow !== eo) begin
            n_fail++;
            $display("FAIL %s: got C=%h zero=%b ovf=%b, required C=%h zero=%b ovf=%b",
                     name, C, zero, overflow, ec, ez, eo);
        end
    endtask

    logic [31:0] specials [8] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF,
                                  32'h80000000, 32'h80000001, 32'h7FFFFFFE, 32'h0000001F};

    function automatic logic [31:0] pick();
        if ($urandom_range(3) == 0) return specials[$urandom_range(7)];
        return $urandom;
    endfunction

    initial begin
        reset = 1'b0; en = 1'b1; A = 32'd5; B = 32'd7; ALUop = 4'b0000;

        // Reset and release
        cyc(0, 1, 5, 7, 4'b0000);
        cyc(0, 1, 5, 7, 4'b0000);
        chk("reset_vals", 32'd0, 1'b1, 1'b0);
        cyc(1, 1, 5, 7, 4'b0000);
        chk("first_addu", 32'd12, 1'b0, 1'b0);

        // SLT sweep against B=-3
        cyc(1, 1, -6, -3, 4'b0111); chk("slt_m6", 32'd1, 1'b0, 1'b0);
        cyc(1, 1, -5, -3, 4'b0111); chk("slt_m5", 32'd1, 1'b0, 1'b0);
        cyc(1, 1, -4, -3, 4'b0111); chk("slt_m4", 32'd1, 1'b0, 1'b0);
        cyc(1, 1, -3, -3, 4'b0111); chk("slt_m3", 32'd0, 1'b1, 1'b0);
        cyc(1, 1, -2, -3, 4'b0111); chk("slt_m2", 32'd0, 1'b1, 1'b0);
        cyc(1, 1, -6, -3, 4'b0110); chk("sltu_lt", 32'd1, 1'b0, 1'b0);
        cyc(1, 1, -3, -6, 4'b0110); chk("sltu_ge", 32'd0, 1'b1, 1'b0);

        // Overflow
        cyc(1, 1, 32'h7FFFFFFF, 32'd1, 4'b1100); chk("add_ovf", 32'h80000000, 1'b0, 1'b1);
        cyc(1, 1, 32'h7FFFFFFF, 32'd1, 4'b0000); chk("addu_noovf", 32'h80000000, 1'b0, 1'b0);
        cyc(1, 1, 32'h80000000, 32'd1, 4'b1101); chk("sub_ovf", 32'h7FFFFFFF, 1'b0, 1'b1);

        // Shifts
        cyc(1, 1, 32'd4, 32'h80000010, 4'b1000); chk("sll", 32'h00000100, 1'b0, 1'b0);
        cyc(1, 1, 32'd4, 32'h80000010, 4'b1001); chk("srl", 32'h08000001, 1'b0, 1'b0);
        cyc(1, 1, 32'd4, 32'h80000010, 4'b1010); chk("sra", 32'hF8000001, 1'b0, 1'b0);
        cyc(1, 1, 32'hFFFFFFE0, 32'h80000010, 4'b1010); chk("sra_zero_amt", 32'h80000010, 1'b0, 1'b0);

        // Logic and LUI
        cyc(1, 1, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0010); chk("and", 32'h00F000F0, 1'b0, 1'b0);
        cyc(1, 1, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0011); chk("or", 32'hFFF0FFF0, 1'b0, 1'b0);
        cyc(1, 1, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0100); chk("xor", 32'hFF00FF00, 1'b0, 1'b0);
        cyc(1, 1, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0101); chk("nor", 32'h000F000F, 1'b0, 1'b0);
        cyc(1, 1, 32'hF0F0F0F0, 32'h00001234, 4'b1011); chk("lui", 32'h12340000, 1'b0, 1'b0);

        // Enable hold, then reset overriding en=0
        cyc(1, 1, 32'd100, 32'd23, 4'b0000); chk("hold_capture", 32'd123, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, $urandom, $urandom, 4'($urandom));
            chk("hold", 32'd123, 1'b0, 1'b0);
        end
        cyc(0, 0, $urandom, $urandom, 4'($urandom)); chk("reset_over_en", 32'd0, 1'b1, 1'b0);

        // Randomized traffic, checked by the per-cycle model compare
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(49) != 0), ($urandom_range(3) != 0), pick(), pick(), 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
